// File: rtl/feistel_pkg.sv
// rtl/feistel_pkg.sv - shared Feistel state encoding, default sizes and round-index width
package feistel_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int DEF_DATAW   = 16;
    localparam int DEF_NROUNDS = 8;

    // A single-round cipher still needs a one-bit index port.
    function automatic int rnd_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/feistel_encrypt_if.sv
// rtl/feistel_encrypt_if.sv - plaintext, round-key and ciphertext handshake bundle
interface feistel_encrypt_if #(
    parameter int DATAW = 16,
    parameter int RNDW  = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] pt_l;
    logic [DATAW-1:0] pt_r;
    logic [RNDW-1:0]  rkey_idx;
    logic [DATAW-1:0] rkey;
    logic             out_valid;
    logic             out_ready;
    logic [DATAW-1:0] ct_l;
    logic [DATAW-1:0] ct_r;
    logic             busy;

    modport master (
        output in_valid, pt_l, pt_r, rkey, out_ready,
        input  in_ready, rkey_idx, out_valid, ct_l, ct_r, busy
    );

    modport slave (
        input  in_valid, pt_l, pt_r, rkey, out_ready,
        output in_ready, rkey_idx, out_valid, ct_l, ct_r, busy
    );
endinterface

// File: rtl/feistel_encrypt_round.sv
// rtl/feistel_encrypt_round.sv - shared round function o = r ^ F(l, c), F = (rotl(l,5) + c) ^ (l >> 1)
module round #(
    parameter int DATAW = 16
) (
    input  logic [DATAW-1:0] l_i,
    input  logic [DATAW-1:0] r_i,
    input  logic [DATAW-1:0] c_i,
    output logic [DATAW-1:0] o_o
);
    logic [DATAW-1:0] rot;
    logic [DATAW-1:0] f_val;

    assign rot   = {l_i[DATAW-6:0], l_i[DATAW-1:DATAW-5]};
    assign f_val = (rot + c_i) ^ (l_i >> 1);
    assign o_o   = r_i ^ f_val;
endmodule

// File: rtl/feistel_encrypt.sv
// rtl/feistel_encrypt.sv - iterative Feistel encryptor, one round per clock, keys k0..k(N-1)
module feistel_encrypt
    import feistel_pkg::*;
#(
    parameter int DATAW   = DEF_DATAW,
    parameter int NROUNDS = DEF_NROUNDS,
    parameter int RNDW    = rnd_width(NROUNDS)
) (
    input logic              clk,
    input logic              reset,
    feistel_encrypt_if.slave bus
);
    localparam logic [RNDW-1:0] LAST_RND = RNDW'(NROUNDS - 1);

    state_e           state_q, state_d;
    logic [DATAW-1:0] l_q, l_d;
    logic [DATAW-1:0] r_q, r_d;
    logic [RNDW-1:0]  rnd_q, rnd_d;
    logic [DATAW-1:0] round_out;

    round #(.DATAW(DATAW)) u_round (
        .l_i (r_q),
        .r_i (l_q),
        .c_i (bus.rkey),
        .o_o (round_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            l_q     <= '0;
            r_q     <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            l_q     <= l_d;
            r_q     <= r_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        l_d     = l_q;
        r_d     = r_q;
        rnd_d   = rnd_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    l_d     = bus.pt_l;
                    r_d     = bus.pt_r;
                    rnd_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                l_d = r_q;
                r_d = round_out;
                if (rnd_q == LAST_RND) begin
                    rnd_d   = '0;
                    state_d = DONE;
                end else begin
                    rnd_d = rnd_q + RNDW'(1);
                end
            end
            DONE: begin
                // Consuming the ciphertext and loading the next block share one edge.
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        l_d     = bus.pt_l;
                        r_d     = bus.pt_r;
                        rnd_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == RUN);
    assign bus.rkey_idx  = (state_q == RUN) ? rnd_q : '0;
    assign bus.ct_l      = l_q;
    assign bus.ct_r      = r_q;

endmodule
